// File: rtl/conv2_ctrl.sv
// conv2 layer sequencer: raster-scans the valid 3x3 window positions of one
// feature map, issues one window fetch per cycle, tracks each window through
// the fixed fetch+filter latency and strobes the output write with its address.
module conv2_ctrl #(
  parameter int unsigned IMG_W    = 14,
  parameter int unsigned IMG_H    = 14,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned FILT_LAT = 4,
  parameter int unsigned CW       = 8,
  parameter int unsigned AW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic          win_rd_en,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          out_wr_en,
  output logic [AW-1:0] out_addr
);

  localparam int unsigned LAT = RD_LAT + FILT_LAT;
  localparam int unsigned OW  = IMG_W - 2;
  localparam int unsigned OH  = IMG_H - 2;
  localparam int unsigned N   = OW * OH;

  localparam logic [CW-1:0] COL_LAST  = CW'(OW - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(OH - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] row, col;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] win_addr;

  logic          trk_v [LAT];
  logic [AW-1:0] trk_a [LAT];

  logic          issue, last_win;
  logic [CW-1:0] cur_row, cur_col, nxt_row, nxt_col;
  logic [AW-1:0] cur_addr;

  // The output address runs as its own counter: in raster order it always
  // equals row*OW+col, so no multiplier is needed.
  // Issue decision and next raster position; a start in IDLE issues (0,0) at once.
  always_comb begin
    cur_row  = row;
    cur_col  = col;
    cur_addr = addr_cnt;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        cur_row  = '0;
        cur_col  = '0;
        cur_addr = '0;
        issue    = start;
      end
      RUN:     issue = !pause;
      default: issue = 1'b0;
    endcase
    last_win = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    if (cur_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = cur_row + CW'(1);
    end else begin
      nxt_col = cur_col + CW'(1);
      nxt_row = cur_row;
    end
  end

  // Sequencer FSM with registered window-request, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_rd_en <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_addr  <= '0;
      row       <= '0;
      col       <= '0;
      addr_cnt  <= '0;
    end else begin
      win_rd_en <= issue;
      done      <= 1'b0;
      if (issue) begin
        win_row  <= cur_row;
        win_col  <= cur_col;
        win_addr <= cur_addr;
        row      <= nxt_row;
        col      <= nxt_col;
        addr_cnt <= cur_addr + AW'(1);
      end
      unique case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          state <= last_win ? DRAIN : RUN;
        end
        RUN: if (!pause && last_win) state <= DRAIN;
        DRAIN: if (out_wr_en && (out_addr == ADDR_LAST)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running tracking shift register fed by the issued request; its head
  // lands exactly LAT cycles after win_rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        trk_v[i] <= 1'b0;
        trk_a[i] <= '0;
      end
    end else begin
      trk_v[0] <= win_rd_en;
      trk_a[0] <= win_addr;
      for (int unsigned i = 1; i < LAT; i++) begin
        trk_v[i] <= trk_v[i-1];
        trk_a[i] <= trk_a[i-1];
      end
    end
  end

  assign out_wr_en = trk_v[LAT-1];
  assign out_addr  = trk_a[LAT-1];

endmodule

// File: tb/tb_conv2_ctrl.sv
// Scoreboard bench for conv2_ctrl: a 5x5 instance exercised through
// baseline, pause, drain-pause, ignored starts and mid-pass reset, plus a
// 3x3 single-window instance.
module tb_conv2_ctrl;

  localparam int unsigned LAT = 5;
  localparam int unsigned OW  = 3;
  localparam int unsigned OH  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic       pause = 1'b0;

  logic       busy, done, win_rd_en, out_wr_en;
  logic [7:0] win_row, win_col;
  logic [15:0] out_addr;

  logic       busy3, done3, win_rd_en3, out_wr_en3;
  logic [7:0] win_row3, win_col3;
  logic [15:0] out_addr3;

  conv2_ctrl #(.IMG_W(5), .IMG_H(5), .RD_LAT(1), .FILT_LAT(4), .CW(8), .AW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .busy(busy), .done(done), .win_rd_en(win_rd_en), .win_row(win_row),
    .win_col(win_col), .out_wr_en(out_wr_en), .out_addr(out_addr)
  );

  conv2_ctrl #(.IMG_W(3), .IMG_H(3), .RD_LAT(1), .FILT_LAT(4), .CW(8), .AW(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .pause(pause),
    .busy(busy3), .done(done3), .win_rd_en(win_rd_en3), .win_row(win_row3),
    .win_col(win_col3), .out_wr_en(out_wr_en3), .out_addr(out_addr3)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after rising edge n, cyc == n.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned e;
    int unsigned a;
    int unsigned b;
  } ev_t;

  ev_t win_q[$];
  ev_t out_q[$];
  ev_t wev, oev;

  int unsigned done_at = 0;
  int unsigned busy_lo = 1;
  int unsigned busy_hi = 0;
  int unsigned pl = 0, ph = 0;
  bit          mon_on = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected schedule for one pass started by a start sampled at edge s.
  // Pause is sampled on edges [p0,p1); abort != 0 is the edge that samples rst.
  task automatic plan(input int unsigned s, input int unsigned p0,
                      input int unsigned p1, input int unsigned abort);
    int unsigned e = s;
    int unsigned last_e = s;
    for (int unsigned r = 0; r < OH; r++) begin
      for (int unsigned c = 0; c < OW; c++) begin
        if (e > s) while (e >= p0 && e < p1) e++;
        if (abort == 0 || e < abort) begin
          win_q.push_back('{e: e, a: r, b: c});
          if (abort == 0 || e + LAT < abort)
            out_q.push_back('{e: e + LAT, a: r * OW + c, b: 0});
          last_e = e;
        end
        e++;
      end
    end
    busy_lo = s;
    if (abort == 0) begin
      busy_hi = last_e + LAT + 1;
      done_at = busy_hi;
    end else begin
      busy_hi = abort - 1;
      done_at = 0;
    end
  endtask

  // Scoreboard monitor for the 5x5 instance, sampled away from the rising edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (win_q.size() > 0 && win_q[0].e == cyc) begin
        wev = win_q.pop_front();
        chk("win_en", int'(win_rd_en), 1);
        chk("win_row", int'(win_row), wev.a);
        chk("win_col", int'(win_col), wev.b);
      end else begin
        chk("win_idle", int'(win_rd_en), 0);
      end
      if (out_q.size() > 0 && out_q[0].e == cyc) begin
        oev = out_q.pop_front();
        chk("out_en", int'(out_wr_en), 1);
        chk("out_addr", int'(out_addr), oev.a);
      end else begin
        chk("out_idle", int'(out_wr_en), 0);
      end
      chk("done", int'(done), int'(cyc == done_at));
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic tick();
    @(negedge clk);
    pause = (cyc + 1 >= pl) && (cyc + 1 < ph);
  endtask

  // Return at the negedge just before rising edge n.
  task automatic wait_until(input int unsigned n);
    while (cyc + 1 < n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned s1, s2, s3, s4, s5;

    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_win_en", int'(win_rd_en), 0);
    chk("rst_out_en", int'(out_wr_en), 0);
    chk("rst_win_row", int'(win_row), 0);
    chk("rst_win_col", int'(win_col), 0);
    chk("rst_out_addr", int'(out_addr), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick();
    tick();

    // Baseline pass with extra starts while busy (must be ignored).
    s1 = cyc + 1;
    plan(s1, 0, 0, 0);
    pulse_start();
    wait_until(s1 + 2);
    pulse_start();
    wait_until(s1 + 11);
    pulse_start();

    // Back-to-back pass after done, paused for 3 cycles after the 4th issue.
    wait_until(s1 + 16);
    s2 = cyc + 1;
    plan(s2, s2 + 4, s2 + 7, 0);
    pl = s2 + 4;
    ph = s2 + 7;
    pulse_start();

    // Pause held only during drain: timing identical to baseline.
    wait_until(s2 + 20);
    s3 = cyc + 1;
    plan(s3, s3 + 9, s3 + 13, 0);
    pl = s3 + 9;
    ph = s3 + 13;
    pulse_start();

    // Reset after three issues: nothing further may come out.
    wait_until(s3 + 17);
    s4 = cyc + 1;
    plan(s4, 0, 0, s4 + 3);
    pulse_start();
    wait_until(s4 + 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_win_row", int'(win_row), 0);
    chk("abort_win_col", int'(win_col), 0);
    chk("abort_out_addr", int'(out_addr), 0);
    wait_until(s4 + 20);

    // Single-window 3x3 map.
    s5 = cyc + 1;
    start3 = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      start3 = 1'b0;
      chk("t3_win_en", int'(win_rd_en3), int'(cyc == s5));
      if (cyc == s5) begin
        chk("t3_win_row", int'(win_row3), 0);
        chk("t3_win_col", int'(win_col3), 0);
      end
      chk("t3_out_en", int'(out_wr_en3), int'(cyc == s5 + 5));
      if (cyc == s5 + 5) chk("t3_out_addr", int'(out_addr3), 0);
      chk("t3_done", int'(done3), int'(cyc == s5 + 6));
      chk("t3_busy", int'(busy3), int'(cyc <= s5 + 6));
    end

    chk("win_q_left", win_q.size(), 0);
    chk("out_q_left", out_q.size(), 0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2_ctrl.md
Name: conv2_ctrl

Overview:
Sequencer for the conv2 layer datapath (64 parallel 3x3 filters fed with one 9-word window per cycle). It scans a single input feature map in raster order with valid convolution (no padding, stride 1), issuing one window-fetch request per cycle. It tracks each window through the fixed fetch and filter pipeline latency, asserts the output write strobe with the matching output address exactly when filter results are valid, and signals completion.

Parameters:
IMG_W, 14, input feature map width in pixels; must be >= 3.
IMG_H, 14, input feature map height in pixels; must be >= 3.
RD_LAT, 1, cycles from win_rd_en to the 9-word window being stable at the filter inputs.
FILT_LAT, 4, cycles from window at the filter inputs to conv2 outputs valid.
CW, 8, width of row/column coordinates.
AW, 16, width of the output address.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  single-cycle pulse; begins a full-map pass; honoured only in IDLE.
pause  input  1  level; while high in RUN, no new window is issued; in-flight windows still complete.
busy  output  1  high in every state except IDLE.
done  output  1  single-cycle pulse at pass completion.
win_rd_en  output  1  window-fetch request, one per issued window.
win_row  output  CW  top-left row of the requested window.
win_col  output  CW  top-left column of the requested window.
out_wr_en  output  1  conv2 outputs valid this cycle; write all 64 results.
out_addr  output  AW  output pixel index = row*(IMG_W-2)+col of the originating window.

Behaviour:
- LAT = RD_LAT + FILT_LAT. OW = IMG_W-2, OH = IMG_H-2, N = OW*OH windows per pass.
- Reset: state IDLE; busy, done, win_rd_en, out_wr_en = 0; win_row, win_col, out_addr = 0; row/col counters and the whole tracking pipeline cleared. Reset mid-pass aborts immediately. No out_wr_en is produced for windows issued before reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN; counters row=col=0. All other inputs are ignored.
- RUN: on a cycle with pause=0, assert win_rd_en with win_row=row and win_col=col (registered outputs, same cycle). Push {valid=1, addr=row*OW+col} into the LAT-deep tracking shift register, then advance the counters. If col==OW-1, col wraps to 0 and row increments; otherwise col increments. With pause=1: win_rd_en=0, counters hold, and a bubble (valid=0) is pushed. On issuing the last window (row=OH-1, col=OW-1) -> DRAIN.
- The tracking shift register advances every cycle and is never stalled; the filter pipeline has no enable. Its head drives out_wr_en/out_addr, so out_wr_en occurs exactly LAT cycles after the matching win_rd_en.
- DRAIN: no issue; pause ignored. When the final window's out_wr_en cycle occurs -> DONE on the next edge.
- DONE: done=1 for exactly one cycle, busy=1; -> IDLE. done is therefore asserted the cycle after the last out_wr_en.
- start while busy is ignored. No restart and no queuing.
- Exactly N out_wr_en pulses per unaborted pass. out_addr is strictly increasing 0..N-1.
- out_addr arithmetic is performed in AW bits. N-1 must fit in AW and max(OW,OH)-1 must fit in CW; these are parameter-legality constraints, not checked in RTL.

Test Plan:
- IMG_W=IMG_H=5, RD_LAT=1, FILT_LAT=4, start at edge t0, pause=0 -> win_rd_en in cycles t0+1..t0+9 with (row,col) = (0,0),(0,1),(0,2),(1,0)..(2,2); out_wr_en in cycles t0+6..t0+14 with out_addr 0..8; done only at t0+15; busy t0+1..t0+15.
- Same config, pause high for 3 cycles starting after the 4th issue -> win_rd_en gap of 3 cycles; out_wr_en gap of 3 cycles shifted by 5; still 9 writes, addresses 0..8; done 3 cycles later than baseline.
- pause asserted during DRAIN -> no effect; timing identical to baseline.
- start re-pulsed at t0+3 and at t0+12 -> ignored; after done, a start at t0+17 -> a new pass begins at t0+18 with (0,0).
- rst asserted at t0+4 for one cycle -> from t0+5 all outputs 0, state IDLE; no out_wr_en for the 3 windows already in flight; done never pulses.
- IMG_W=IMG_H=3 -> single window (0,0), one out_wr_en with out_addr 0 at t0+6, done at t0+7.
